// File: rtl/slice_cnt_pkg.sv
// Shared mode encoding and sizing helper for the slice-loadable counter.
package slice_cnt_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_RLD  = 2'd2,
    MODE_RSV  = 2'd3
  } cnt_mode_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/slice_load_cnt_slice_wr.sv
// Merges one SLICE_W-bit slice of data into a CNT_W-bit value; an out-of-range
// select or a partial top slice simply leaves the missing bits untouched/dropped.
module slice_wr
  import slice_cnt_pkg::*;
#(
  parameter  int CNT_W      = 6,
  parameter  int SLICE_W    = 4,
  localparam int NUM_SLICES = ceil_div(CNT_W, SLICE_W),
  localparam int SEL_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic [CNT_W-1:0]   cur,
  input  logic [SEL_W-1:0]   sel,
  input  logic [SLICE_W-1:0] d,
  input  logic               we,
  output logic [CNT_W-1:0]   nxt
);

  // Each result bit belongs to exactly one slice, so the merge is a per-bit mux.
  for (genvar i = 0; i < CNT_W; i++) begin : g_bit
    assign nxt[i] = (we && (sel == SEL_W'(i / SLICE_W))) ? d[i % SLICE_W] : cur[i];
  end

endmodule

// File: rtl/slice_load_cnt.sv
// Slice-loadable down-counter with zero detect, terminal-count pulse and
// wrap/saturate/auto-reload modes. Up-counting is added by SLICE_CNT_UPDN_EN.
module slice_load_cnt
  import slice_cnt_pkg::*;
#(
  parameter  int CNT_W      = 6,
  parameter  int SLICE_W    = 4,
  localparam int NUM_SLICES = ceil_div(CNT_W, SLICE_W),
  localparam int SEL_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               LD,
  input  logic               TGT,
  input  logic [SEL_W-1:0]   SEL,
  input  logic [SLICE_W-1:0] D,
  input  logic               CE,
  input  logic [1:0]         MODE,
`ifdef SLICE_CNT_UPDN_EN
  input  logic               UP,
`endif
  output logic [CNT_W-1:0]   Q,
  output logic               ZD,
  output logic               TC
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] q_q, q_d, q_wr;
  logic [CNT_W-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             q_ld, rld_ld;
  cnt_mode_t        mode;

  assign q_ld   = LD & ~TGT;
  assign rld_ld = LD & TGT;
  assign mode   = cnt_mode_t'(MODE);

  slice_wr #(.CNT_W(CNT_W), .SLICE_W(SLICE_W)) u_q_wr (
    .cur(q_q), .sel(SEL), .d(D), .we(q_ld), .nxt(q_wr)
  );

  slice_wr #(.CNT_W(CNT_W), .SLICE_W(SLICE_W)) u_rld_wr (
    .cur(rld_q), .sel(SEL), .d(D), .we(rld_ld), .nxt(rld_d)
  );

`ifdef SLICE_CNT_UPDN_EN
  logic [CNT_W-1:0] up_top;
  assign up_top = (mode == MODE_RLD) ? rld_q : ALL_ONES;
`endif

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (q_ld) begin
      q_d = q_wr;
    end else if (CE) begin
`ifdef SLICE_CNT_UPDN_EN
      if (UP) begin
        if (q_q == up_top) begin
          q_d = (mode == MODE_SAT) ? q_q : '0;
        end else begin
          q_d  = q_q + ONE;
          tc_d = ((q_q + ONE) == up_top);
        end
      end else
`endif
      begin
        // Boundary handling only applies at zero; reload/wrap never pulse TC.
        if (q_q != '0) begin
          q_d  = q_q - ONE;
          tc_d = (q_q == ONE);
        end else begin
          case (mode)
            MODE_SAT: q_d = q_q;
            MODE_RLD: q_d = rld_q;
            default:  q_d = ALL_ONES;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_q   <= '0;
      rld_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      rld_q <= rld_d;
      tc_q  <= tc_d;
    end
  end

  assign Q  = q_q;
  assign ZD = (q_q == '0);
  assign TC = tc_q;

endmodule
